// File: rtl/demux_frame_router.sv
// rtl/demux_frame_router.sv - serialises WIDTH-bit words MSB-first onto i with s1/s0 routing for a 1-to-4 demux
module demux_frame_router #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       dest,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             i,
    output logic             s0,
    output logic             s1,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);
    localparam logic [3:0] LAST_GAP = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       s_q, s_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       cnt_q [4];
    logic [7:0]       cnt_d [4];
    logic             accept;

    assign in_ready = (state_q == ST_IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        sel_d        = sel_q;
        s_d          = s_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        bit_valid_d  = bit_valid_q;
        frame_done_d = frame_done_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                bit_valid_d  = 1'b0;
                frame_done_d = 1'b0;
                shreg_d      = '0;
                if (accept) begin
                    shreg_d     = din;
                    sel_d       = dest;
                    s_d         = dest;
                    bit_cnt_d   = '0;
                    bit_valid_d = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    cnt_d[sel_q] = cnt_q[sel_q] + 8'd1;
                    shreg_d      = '0;
                    bit_valid_d  = 1'b0;
                    frame_done_d = 1'b0;
                    gap_cnt_d    = '0;
                    state_d      = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    // i is the shift register MSB, so shifting presents the next bit
                    shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d    = bit_cnt_q + 5'd1;
                    frame_done_d = (bit_cnt_q + 5'd1) == LAST_BIT;
                end
            end
            ST_GAP: begin
                s_d = sel_q;
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                shreg_d     = '0;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            sel_q        <= '0;
            s_q          <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sel_q        <= sel_d;
            s_q          <= s_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign i          = shreg_q[WIDTH-1];
    assign s0         = s_q[0];
    assign s1         = s_q[1];
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];
    assign cnt2       = cnt_q[2];
    assign cnt3       = cnt_q[3];

endmodule

// File: tb/tb_demux_frame_router.sv
// tb/tb_demux_frame_router.sv - self-checking bench for demux_frame_router
module tb_demux_frame_router;

    localparam int WIDTH = 8;
    localparam int GAP   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic [1:0]       dest;
    logic             in_valid;
    logic             in_ready;
    logic             i, s0, s1, bit_valid, frame_done, busy;
    logic [7:0]       cnt0, cnt1, cnt2, cnt3;

    always #5 clk = ~clk;

    demux_frame_router #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .din(din), .dest(dest), .in_valid(in_valid),
        .in_ready(in_ready), .i(i), .s0(s0), .s1(s1), .bit_valid(bit_valid),
        .frame_done(frame_done), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    typedef struct packed {
        logic       i;
        logic [1:0] s;
        logic       bv;
        logic       fd;
    } ent_t;

    // e = {i, s1s0, bit_valid, frame_done, busy, in_ready, cnt2}
    typedef struct packed {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic [1:0]  de;
        logic [14:0] e;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    ent_t       exp_q[$];
    logic [1:0] last_s;
    logic [7:0] mcnt [4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: each accepted word becomes WIDTH frame entries plus GAP idle entries in a queue
    task automatic tick(input logic r, input logic v, input logic [WIDTH-1:0] d,
                        input logic [1:0] de, output logic acc);
        ent_t e;
        logic have;
        have = (exp_q.size() != 0);
        if (have) e = exp_q.pop_front();
        else      e = '{i: 1'b0, s: last_s, bv: 1'b0, fd: 1'b0};
        chk($sformatf("model_c%0d", cyc),
            {25'd0, i, s1, s0, bit_valid, frame_done, busy, in_ready, cnt0, cnt1, cnt2, cnt3},
            {25'd0, e.i, e.s, e.bv, e.fd, have, ~have & ~rst, mcnt[0], mcnt[1], mcnt[2], mcnt[3]});
        last_s   = e.s;
        rst      = r;
        in_valid = v;
        din      = d;
        dest     = de;
        acc      = v && !have && !r;
        if (r) begin
            exp_q.delete();
            last_s = 2'b00;
            for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
        end else begin
            if (e.fd) mcnt[e.s] = mcnt[e.s] + 8'd1;
            if (acc) begin
                for (int k = WIDTH - 1; k >= 0; k--)
                    exp_q.push_back('{i: d[k], s: de, bv: 1'b1, fd: (k == 0)});
                for (int g = 0; g < GAP; g++)
                    exp_q.push_back('{i: 1'b0, s: de, bv: 1'b0, fd: 1'b0});
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_idle();
        logic acc;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick(1'b0, 1'b0, '0, 2'd0, acc);
        if (exp_q.size() != 0) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] de);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) tick(1'b0, 1'b1, d, de, acc);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        wait_idle();
    endtask

    function automatic vec_t row(logic r, logic v, logic [7:0] d, logic [1:0] de, logic ei,
                                 logic [1:0] es, logic ebv, logic efd, logic ebusy,
                                 logic erdy, logic [7:0] ec);
        return '{r: r, v: v, d: d, de: de, e: {ei, es, ebv, efd, ebusy, erdy, ec}};
    endfunction

    initial begin
        vec_t       tbl [16];
        logic [7:0] a5;
        logic       acc, fd_seen;
        logic [1:0] s_prev;
        logic       prev_acc;
        int         a1, a2;

        a5 = 8'hA5;
        for (int k = 0; k < 3; k++) tbl[k] = row(1, 1, 8'hAA, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[3] = row(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4] = row(0, 1, 8'hA5, 2, 0, 0, 0, 0, 0, 1, 0);
        for (int b = 0; b < 8; b++)
            tbl[5 + b] = row(0, b == 1, (b == 1) ? 8'h3C : 8'h00, (b == 1) ? 2'd1 : 2'd0,
                             a5[7 - b], 2, 1, b == 7, 1, 0, 0);
        tbl[13] = row(0, 0, 8'h00, 0, 0, 2, 0, 0, 1, 0, 1);
        tbl[14] = row(0, 0, 8'h00, 0, 0, 2, 0, 0, 0, 1, 1);
        tbl[15] = row(0, 0, 8'h00, 0, 0, 2, 0, 0, 0, 1, 1);

        rst = 1'b1; in_valid = 1'b0; din = '0; dest = '0;
        last_s = 2'b00;
        for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
        @(posedge clk);
        @(negedge clk);

        // Reset with in_valid high, single A5 frame to channel 2, busy-time pulse of 3C
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("vec%0d", k),
                {49'd0, i, s1, s0, bit_valid, frame_done, busy, in_ready, cnt2}, {49'd0, tbl[k].e});
            tick(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].de, acc);
        end
        chk("single_cnt_others", {40'd0, cnt0, cnt1, cnt3}, 64'd0);

        // Back-to-back with in_valid held: FF to ch0 then 01 to ch3
        a1 = -1; a2 = -1; s_prev = {s1, s0}; prev_acc = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if ({s1, s0} != s_prev) chk("s_change_timing", {63'd0, prev_acc}, 64'd1);
            s_prev = {s1, s0};
            if (a1 < 0)      tick(1'b0, 1'b1, 8'hFF, 2'd0, acc);
            else if (a2 < 0) tick(1'b0, 1'b1, 8'h01, 2'd3, acc);
            else             tick(1'b0, 1'b0, 8'h00, 2'd0, acc);
            if (acc) begin
                if (a1 < 0) a1 = cyc;
                else        a2 = cyc;
            end
            prev_acc = acc;
        end
        chk("b2b_period", 64'(a2 - a1), 64'd10);
        chk("b2b_cnt0", {56'd0, cnt0}, 64'd1);
        chk("b2b_cnt3", {56'd0, cnt3}, 64'd1);

        // Reset after three bits of F0 to ch3
        tick(1'b0, 1'b1, 8'hF0, 2'd3, acc);
        tick(1'b0, 1'b0, 8'h00, 2'd0, acc);
        tick(1'b0, 1'b0, 8'h00, 2'd0, acc);
        tick(1'b1, 1'b0, 8'h00, 2'd0, acc);
        chk("midrst_outputs", {52'd0, i, bit_valid, s1, s0, cnt3}, 64'd0);
        fd_seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            fd_seen |= frame_done;
            tick(1'b0, 1'b0, 8'h00, 2'd0, acc);
        end
        chk("midrst_no_frame_done", {63'd0, fd_seen}, 64'd0);

        // 256 frames to ch1
        for (int f = 1; f <= 256; f++) begin
            send(8'($urandom), 2'd1);
            if (f == 255) chk("wrap_255", {56'd0, cnt1}, 64'd255);
            if (f == 256) chk("wrap_0", {56'd0, cnt1}, 64'd0);
        end

        // Random traffic against the queue model
        for (int n = 0; n < 3000; n++)
            tick($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 8'($urandom), 2'($urandom), acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_frame_router.md
# demux_frame_router

Serialises parallel data words into routed bit streams for the 1-to-4 demultiplexer stage. Each accepted word plus 2-bit destination is shifted out MSB-first on `i`, with `s1`/`s0` held at the destination for the whole frame. The block sits directly upstream of the demux and drives its `i`, `s0` and `s1` inputs. It also keeps a per-channel count of completed frames for debug and verification.

## Interface
- `WIDTH`, 8: data bits per frame; legal range 2..16.
- `GAP`, 1: idle cycles inserted after each frame; legal range 0..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  data word; sampled only on acceptance.
- `dest`  in  2  destination channel 0..3; sampled only on acceptance.
- `in_valid`  in  1  upstream offers `din`/`dest`.
- `in_ready`  out  1  block can accept a word; equals (state==IDLE) & ~rst.
- `i`  out  1  serial data bit to the demux; registered.
- `s0`  out  1  destination bit 0 to the demux; registered.
- `s1`  out  1  destination bit 1 to the demux; registered.
- `bit_valid`  out  1  high while `i` carries a frame bit; registered.
- `frame_done`  out  1  high during the last bit of a frame; registered.
- `busy`  out  1  high in SHIFT or GAP.
- `cnt0`..`cnt3`  out  8 each  completed-frame counters per channel.

## Operation
- FSM states are IDLE, SHIFT and GAP. The reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready` at an edge:
    - `shreg`<=`din` and `sel`<=`dest`.
    - `i`<=`din[WIDTH-1]`, `bit_valid`<=1, `bit_cnt`<=0.
    - {`s1`,`s0`}<=`dest`.
    - Go to SHIFT.
  - With no handshake: `i`=0, `bit_valid`=0, and `s1`/`s0` hold their last value.
- **SHIFT**
  - At each edge, shift `shreg` left, drive the next MSB onto `i`, and increment `bit_cnt`.
  - `frame_done` is high in the cycle where `bit_cnt`==WIDTH-1, i.e. the last bit.
  - At the edge ending the last bit:
    - `cnt[sel]` increments; 8-bit, wraps 255->0.
    - `i`<=0, `bit_valid`<=0, `frame_done`<=0.
    - Next state is GAP if `GAP`>0, else IDLE.
- **GAP**
  - Hold `i`=0, `bit_valid`=0 and `s1`/`s0` at `sel` for `GAP` cycles, then go to IDLE.
- `in_valid` while `in_ready`=0 has no effect. `din`/`dest` need not be stable until acceptance.
- No bit is skipped or repeated. The frame bit order is `din[WIDTH-1]` first, down to `din[0]`.
- Reset at any point, including mid-frame:
  - Next state is IDLE and the frame is discarded.
  - No `frame_done`, no counter increment.
  - All outputs take their reset values.

## Timing
- Reset values: `i`=0, `s0`=0, `s1`=0, `bit_valid`=0, `frame_done`=0, `busy`=0, `cnt0`..`cnt3`=0. `in_ready`=0 while `rst`=1.
- Acceptance at edge N puts bit WIDTH-1 on `i` in cycle N+1, so latency is 1 cycle.
- A frame occupies cycles N+1..N+WIDTH. `frame_done` is high in cycle N+WIDTH.
- The counter update is visible in cycle N+WIDTH+1.
- `in_ready` returns high in cycle N+WIDTH+GAP+1.
- Minimum frame period is WIDTH+GAP+1 cycles; back-to-back frames always have one IDLE cycle.
- `s1`/`s0` are stable throughout every cycle in which `bit_valid`=1, so the demux never glitches mid-frame.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `in_valid`=1.
  - All outputs stay at reset values and no frame is accepted.
  - `in_ready`=1 in the first cycle after `rst` falls.
- **Single frame:** WIDTH=8, `din`=8'hA5, `dest`=2.
  - `i` is 1,0,1,0,0,1,0,1 over 8 cycles, with `s1`=1, `s0`=0 and `bit_valid`=1 throughout.
  - `frame_done` is high only on the 8th bit.
  - `cnt2`=1; other counters stay 0.
- **Back-to-back:** GAP=1, `in_valid` held high, `din`=8'hFF to `dest`=0 then `din`=8'h01 to `dest`=3.
  - The second acceptance occurs exactly 10 cycles after the first.
  - `s1`/`s0` change only in the acceptance-following cycle.
  - `cnt0`=1 and `cnt3`=1.
- **Busy ignore:** pulse `in_valid` with `din`=8'h3C during SHIFT.
  - The pulse is not accepted.
  - The current frame bits are unchanged and no extra frame is sent.
- **Counter wrap:** send 256 frames to `dest`=1.
  - `cnt1` reads 255 after the 255th frame and 0 after the 256th.
- **Reset mid-frame:** assert `rst` for 1 cycle after 3 bits of 8'hF0 to `dest`=3.
  - The next cycle shows `i`=0, `bit_valid`=0, `s1`/`s0`=00 and `cnt3`=0.
  - `frame_done` never pulses.
